// File: rtl/wb_stage.sv
// wb_stage: write-back stage with a 2-entry in-order register write buffer.
// Retiring MEM-stage instructions that write a register are queued and issued
// to the register-file write port whenever it is granted. Pending writes are
// forwarded to the decode stage, youngest matching entry first.
module wb_stage #(
  parameter int DEPTH = 2  // fixed at 2; the occupancy FSM assumes two slots
) (
  input  logic        clk,
  input  logic        rst_n,
  // MEM stage handshake and payload
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_reg_write,
  input  logic        mem_to_reg,
  input  logic [3:0]  mem_rdest,
  input  logic [31:0] alu_result,
  input  logic [31:0] load_data,
  // register-file write port
  input  logic        reg_port_grant,
  output logic [3:0]  rwrite,
  output logic        write_reg_signal,
  output logic [31:0] write_data,
  // decode-stage forwarding lookup
  input  logic [3:0]  rprimary_base,
  input  logic [3:0]  rsecondary_store,
  output logic        fwd_primary_hit,
  output logic [31:0] fwd_primary_data,
  output logic        fwd_secondary_hit,
  output logic [31:0] fwd_secondary_data,
  // retirement statistics
  output logic [15:0] retire_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic [3:0]  rdest;
    logic [31:0] data;
  } entry_t;

  occ_t   state_q, state_d;
  entry_t entries [DEPTH];
  logic   rd_ptr;       // slot holding the oldest (head) entry
  logic   wr_ptr;       // slot the next push lands in
  logic   accept;
  logic   push;
  logic   pop;
  logic   non_empty;
  entry_t head;
  entry_t tail;
  entry_t push_entry;

  // Returns {hit, data}; the tail is checked last so the youngest match wins.
  function automatic logic [32:0] fwd_lookup(input occ_t       occ,
                                             input entry_t     head_e,
                                             input entry_t     tail_e,
                                             input logic [3:0] reg_num);
    logic        hit;
    logic [31:0] data;
    hit  = 1'b0;
    data = '0;
    if (occ != EMPTY && head_e.rdest == reg_num) begin
      hit  = 1'b1;
      data = head_e.data;
    end
    if (occ == FULL && tail_e.rdest == reg_num) begin
      hit  = 1'b1;
      data = tail_e.data;
    end
    return {hit, data};
  endfunction

  // Handshake, push/pop qualification and the entry being written.
  always_comb begin
    non_empty        = (state_q != EMPTY);
    mem_ready        = (state_q != FULL);
    accept           = mem_valid & mem_ready;
    push             = accept & mem_reg_write;
    write_reg_signal = non_empty & reg_port_grant;
    pop              = write_reg_signal;
    head             = entries[rd_ptr];
    tail             = entries[~rd_ptr];
    push_entry.rdest = mem_rdest;
    push_entry.data  = mem_to_reg ? load_data : alu_result;
  end

  // Register-file write port shows the head entry, zero when nothing is pending.
  always_comb begin
    rwrite     = '0;
    write_data = '0;
    if (non_empty) begin
      rwrite     = head.rdest;
      write_data = head.data;
    end
  end

  // Forwarding looks only at buffered entries, never at this cycle's MEM inputs.
  always_comb begin
    {fwd_primary_hit, fwd_primary_data}     = fwd_lookup(state_q, head, tail, rprimary_base);
    {fwd_secondary_hit, fwd_secondary_data} = fwd_lookup(state_q, head, tail, rsecondary_store);
  end

  // Occupancy next-state logic.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Buffer storage and circular pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      // NOTE: entries are cleared on reset because stale contents must never be observable; a plain data RAM would normally skip this.
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  // Retirement counter: every accepted instruction, writing or not; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retire_count <= '0;
    else if (accept) retire_count <= retire_count + 16'd1;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a directed vector table covering
// pass-through, backpressure, forwarding priority, simultaneous push/pop and
// non-writing retirement, plus hand sequences for reset and counter wrap.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_ready, mem_reg_write, mem_to_reg;
  logic [3:0]  mem_rdest;
  logic [31:0] alu_result, load_data;
  logic        reg_port_grant;
  logic [3:0]  rwrite;
  logic        write_reg_signal;
  logic [31:0] write_data;
  logic [3:0]  rprimary_base, rsecondary_store;
  logic        fwd_primary_hit, fwd_secondary_hit;
  logic [31:0] fwd_primary_data, fwd_secondary_data;
  logic [15:0] retire_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.DEPTH(2)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mem_valid          (mem_valid),
    .mem_ready          (mem_ready),
    .mem_reg_write      (mem_reg_write),
    .mem_to_reg         (mem_to_reg),
    .mem_rdest          (mem_rdest),
    .alu_result         (alu_result),
    .load_data          (load_data),
    .reg_port_grant     (reg_port_grant),
    .rwrite             (rwrite),
    .write_reg_signal   (write_reg_signal),
    .write_data         (write_data),
    .rprimary_base      (rprimary_base),
    .rsecondary_store   (rsecondary_store),
    .fwd_primary_hit    (fwd_primary_hit),
    .fwd_primary_data   (fwd_primary_data),
    .fwd_secondary_hit  (fwd_secondary_hit),
    .fwd_secondary_data (fwd_secondary_data),
    .retire_count       (retire_count)
  );

  // Inputs applied for one cycle and the outputs expected just before the next edge.
  typedef struct {
    logic [31:0] valid, reg_write, to_reg, rdest, alu, load, grant, rp, rs;
    logic [31:0] e_ready, e_wrs, e_rw, e_wd, e_phit, e_pd, e_shit, e_sd, e_rc;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic mtr, input logic [3:0] rd,
                       input logic [31:0] alu, input logic [31:0] ld, input logic g,
                       input logic [3:0] rp, input logic [3:0] rs);
    mem_valid        = v;
    mem_reg_write    = rw;
    mem_to_reg       = mtr;
    mem_rdest        = rd;
    alu_result       = alu;
    load_data        = ld;
    reg_port_grant   = g;
    rprimary_base    = rp;
    rsecondary_store = rs;
  endtask

  task automatic check_idle(input string tag, input logic [15:0] rc);
    check({tag, " ready"}, {31'd0, mem_ready}, 32'd1);
    check({tag, " wrs"},   {31'd0, write_reg_signal}, 32'd0);
    check({tag, " rw"},    {28'd0, rwrite}, 32'd0);
    check({tag, " wd"},    write_data, 32'd0);
    check({tag, " phit"},  {31'd0, fwd_primary_hit}, 32'd0);
    check({tag, " pd"},    fwd_primary_data, 32'd0);
    check({tag, " shit"},  {31'd0, fwd_secondary_hit}, 32'd0);
    check({tag, " sd"},    fwd_secondary_data, 32'd0);
    check({tag, " rc"},    {16'd0, retire_count}, {16'd0, rc});
  endtask

  initial begin
    //           valid rw mtr rd alu            load           g rp rs  rdy wrs rw wd              phit pd             shit sd             rc
    vecs[0]  = '{0, 0, 0, 0, 0,             0,             1, 0, 0,  1, 0, 0, 0,              0, 0,              0, 0,              0};
    vecs[1]  = '{1, 1, 1, 5, 32'h12345678,  32'hDEADBEEF,  1, 5, 0,  1, 0, 0, 0,              0, 0,              0, 0,              0};
    vecs[2]  = '{0, 0, 0, 0, 0,             0,             1, 5, 5,  1, 1, 5, 32'hDEADBEEF,   1, 32'hDEADBEEF,   1, 32'hDEADBEEF,   1};
    vecs[3]  = '{0, 0, 0, 0, 0,             0,             1, 5, 5,  1, 0, 0, 0,              0, 0,              0, 0,              1};
    vecs[4]  = '{1, 1, 0, 3, 32'h11,        32'hFFFF,      0, 0, 0,  1, 0, 0, 0,              0, 0,              0, 0,              1};
    vecs[5]  = '{1, 1, 0, 4, 32'h22,        0,             0, 3, 4,  1, 0, 3, 32'h11,         1, 32'h11,         0, 0,              2};
    vecs[6]  = '{1, 1, 0, 9, 32'h99,        0,             0, 4, 3,  0, 0, 3, 32'h11,         1, 32'h22,         1, 32'h11,         3};
    vecs[7]  = '{0, 0, 0, 0, 0,             0,             1, 4, 3,  0, 1, 3, 32'h11,         1, 32'h22,         1, 32'h11,         3};
    vecs[8]  = '{0, 0, 0, 0, 0,             0,             1, 4, 3,  1, 1, 4, 32'h22,         1, 32'h22,         0, 0,              3};
    vecs[9]  = '{0, 0, 0, 0, 0,             0,             1, 4, 3,  1, 0, 0, 0,              0, 0,              0, 0,              3};
    vecs[10] = '{1, 1, 0, 7, 32'hA,         0,             0, 7, 2,  1, 0, 0, 0,              0, 0,              0, 0,              3};
    vecs[11] = '{1, 1, 0, 7, 32'hB,         0,             0, 7, 2,  1, 0, 7, 32'hA,          1, 32'hA,          0, 0,              4};
    vecs[12] = '{0, 0, 0, 0, 0,             0,             0, 7, 2,  0, 0, 7, 32'hA,          1, 32'hB,          0, 0,              5};
    vecs[13] = '{0, 0, 0, 0, 0,             0,             1, 7, 2,  0, 1, 7, 32'hA,          1, 32'hB,          0, 0,              5};
    vecs[14] = '{1, 1, 1, 0, 32'h1,         32'hC0FFEE00,  1, 0, 7,  1, 1, 7, 32'hB,          0, 0,              1, 32'hB,          5};
    vecs[15] = '{0, 0, 0, 0, 0,             0,             0, 0, 0,  1, 0, 0, 32'hC0FFEE00,   1, 32'hC0FFEE00,   1, 32'hC0FFEE00,   6};
    vecs[16] = '{0, 0, 0, 0, 0,             0,             1, 0, 0,  1, 1, 0, 32'hC0FFEE00,   1, 32'hC0FFEE00,   1, 32'hC0FFEE00,   6};
    vecs[17] = '{1, 0, 0, 6, 32'h66,        0,             1, 6, 6,  1, 0, 0, 0,              0, 0,              0, 0,              6};
    vecs[18] = '{0, 0, 0, 0, 0,             0,             1, 6, 6,  1, 0, 0, 0,              0, 0,              0, 0,              7};

    // Reset with the write port granted: nothing may issue.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    #1 check_idle("reset", 16'd0);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].valid[0], vecs[i].reg_write[0], vecs[i].to_reg[0], vecs[i].rdest[3:0],
            vecs[i].alu, vecs[i].load, vecs[i].grant[0], vecs[i].rp[3:0], vecs[i].rs[3:0]);
      #1;
      check($sformatf("v%0d ready", i), {31'd0, mem_ready}, vecs[i].e_ready);
      check($sformatf("v%0d wrs", i),   {31'd0, write_reg_signal}, vecs[i].e_wrs);
      check($sformatf("v%0d rw", i),    {28'd0, rwrite}, vecs[i].e_rw);
      check($sformatf("v%0d wd", i),    write_data, vecs[i].e_wd);
      check($sformatf("v%0d phit", i),  {31'd0, fwd_primary_hit}, vecs[i].e_phit);
      check($sformatf("v%0d pd", i),    fwd_primary_data, vecs[i].e_pd);
      check($sformatf("v%0d shit", i),  {31'd0, fwd_secondary_hit}, vecs[i].e_shit);
      check($sformatf("v%0d sd", i),    fwd_secondary_data, vecs[i].e_sd);
      check($sformatf("v%0d rc", i),    {16'd0, retire_count}, vecs[i].e_rc);
    end

    // Mid-operation reset: fill the buffer, then pulse reset between edges.
    @(negedge clk) drive(1, 1, 0, 8, 32'h80, 0, 0, 8, 9);
    @(negedge clk) drive(1, 1, 0, 9, 32'h90, 0, 0, 8, 9);
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0, 8, 9);
    #1 check("full ready", {31'd0, mem_ready}, 32'd0);
    check("full phit", {31'd0, fwd_primary_hit}, 32'd1);
    check("full shit", {31'd0, fwd_secondary_hit}, 32'd1);
    #1 rst_n = 1'b0;
    reg_port_grant = 1'b1;
    #1 check_idle("midrst", 16'd0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 check_idle($sformatf("postrst%0d", c), 16'd0);
    end

    // First accept lands on the first edge after reset release.
    @(negedge clk) rst_n = 1'b0;
    #1 rst_n = 1'b1;
    drive(1, 1, 0, 1, 32'h55, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    check("first rc", {16'd0, retire_count}, 32'd1);
    check("first rw", {28'd0, rwrite}, 32'd1);
    check("first wd", write_data, 32'h55);
    check("first phit", {31'd0, fwd_primary_hit}, 32'd1);
    mem_valid = 1'b0;

    // Counter wrap: 65535 non-writing accepts, then one more.
    @(negedge clk) rst_n = 1'b0;
    #1 rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (65535) @(posedge clk);
    #1;
    check("wrap pre rc", {16'd0, retire_count}, 32'h0000FFFF);
    check("wrap pre wrs", {31'd0, write_reg_signal}, 32'd0);
    check("wrap pre ready", {31'd0, mem_ready}, 32'd1);
    @(posedge clk);
    #1 check("wrap rc", {16'd0, retire_count}, 32'd0);
    mem_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: DEPTH, 2, write-buffer entries; fixed at 2, no other value supported.
REQ-002 ClockInput  in  1  single clock; all state updates on rising edge.
REQ-003 ResetInputN  in  1  reset, asynchronous, active-low.
REQ-004 MemValid  in  1  MEM stage presents a retiring instruction.
REQ-005 MemReady  out  1  wb_stage can accept this cycle.
REQ-006 MemRegWrite  in  1  instruction writes a register.
REQ-007 MemToReg  in  1  1 = write LoadData, 0 = write AluResult.
REQ-008 MemRdest  in  4  destination register number.
REQ-009 AluResult  in  32  ALU result from MEM stage.
REQ-010 LoadData  in  32  load data from data memory.
REQ-011 RegPortGrant  in  1  register-file write port available this cycle.
REQ-012 Rwrite  out  4  register number to register file.
REQ-013 WriteRegSignal  out  1  register-file write enable.
REQ-014 WriteData  out  32  register-file write data.
REQ-015 Rprimary_base  in  4  decode-stage primary/base register number.
REQ-016 Rsecondary_store  in  4  decode-stage secondary/store register number.
REQ-017 FwdPrimaryHit / FwdPrimaryData  out  1 / 32  pending write matching Rprimary_base, and its data.
REQ-018 FwdSecondaryHit / FwdSecondaryData  out  1 / 32  pending write matching Rsecondary_store, and its data.
REQ-019 RetireCount  out  16  count of accepted instructions.

Function
REQ-020 Buffer SHALL be an in-order 2-entry FIFO of {Rdest[3:0], Data[31:0]}; occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-021 MemReady SHALL be 1 iff occupancy < 2; no same-cycle bypass of a pop when FULL.
REQ-022 Accept = MemValid & MemReady; on accept with MemRegWrite=1, push {MemRdest, MemToReg ? LoadData : AluResult}.
REQ-023 Accept with MemRegWrite=0 SHALL not push; it counts as retired only.
REQ-024 WriteRegSignal SHALL equal (occupancy != 0) & RegPortGrant, combinationally; Rwrite/WriteData SHALL show head entry whenever non-empty, else 0.
REQ-025 Pop SHALL occur at the rising edge where WriteRegSignal = 1; write latency accept->WriteRegSignal minimum 1 cycle.
REQ-026 Simultaneous push and pop: EMPTY stays EMPTY only if no push; ONE stays ONE (head written, new entry becomes head); FULL cannot push (REQ-021).
REQ-027 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; FULL->ONE on pop.
REQ-028 Writes to register 0 SHALL be buffered and issued like any other register.
REQ-029 FwdPrimaryHit = 1 iff a valid entry has Rdest == Rprimary_base; FwdPrimaryData SHALL be the youngest matching entry's data, else 0; same rule for secondary.
REQ-030 Forwarding SHALL consider buffered entries only, not the MEM-stage inputs of the current cycle; an entry popped this cycle still forwards this cycle.
REQ-031 RetireCount SHALL increment by 1 on every accept, wrapping 0xFFFF->0x0000.
REQ-032 Buffer order SHALL be preserved: writes to the same register issue in acceptance order.

Reset
REQ-033 ResetInputN low SHALL immediately clear occupancy to EMPTY, RetireCount to 0, all entry fields to 0.
REQ-034 During and after reset: MemReady=1, WriteRegSignal=0, Rwrite=0, WriteData=0, all Fwd outputs 0.
REQ-035 Reset asserted mid-operation SHALL discard all pending writes; no register-file write issues in the reset cycle.
REQ-036 First accept SHALL occur on the first rising edge after ResetInputN deasserts.

Verification
REQ-037 Load pass-through: RegPortGrant=1, accept {Rdest=5, MemToReg=1, LoadData=0xDEADBEEF} -> next cycle WriteRegSignal=1, Rwrite=5, WriteData=0xDEADBEEF; following cycle EMPTY, RetireCount=1.
REQ-038 Backpressure: RegPortGrant=0, accept Rdest=3 (0x11) then Rdest=4 (0x22) -> MemReady=0; raise grant -> writes 3/0x11 then 4/0x22 on consecutive cycles, MemReady=1 after first pop.
REQ-039 Forwarding priority: grant=0, buffer Rdest=7 0xA then Rdest=7 0xB; Rprimary_base=7 -> FwdPrimaryHit=1, FwdPrimaryData=0xB; Rsecondary_store=2 -> FwdSecondaryHit=0, data 0.
REQ-040 Non-writing instruction: accept MemRegWrite=0 -> no push, WriteRegSignal stays 0, RetireCount +1.
REQ-041 Reset mid-operation: FULL with grant=0, pulse ResetInputN low between edges -> outputs zero immediately, MemReady=1, RetireCount=0, no write after release.
REQ-042 Counter wrap: preload via 65535 accepts then one more -> RetireCount=0x0000.
